// File: rtl/tm_reorder_pkg.sv
// Shared constants and types for the master-side reply reorder block.
package tm_reorder_pkg;

    localparam int unsigned NUM_VCS  = 4;
    localparam int unsigned VC_IDX_W = 2;
    localparam int unsigned ERR_W    = 3;

    typedef logic [VC_IDX_W-1:0] vc_idx_t;

    localparam int unsigned ERR_ORDER_OVF = 0;
    localparam int unsigned ERR_UNEXP     = 1;
    localparam int unsigned ERR_REPLY_OVF = 2;

endpackage

// File: rtl/tm_sync_fifo.sv
// Synchronous show-ahead FIFO with binary pointers and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module tm_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full_c,
    output logic             empty_c,
    output logic             full_next_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full_c;
    assign do_pop  = pop & ~empty_c;
    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    assign rdata_c = mem[rd_ptr];

    // Occupancy after this edge; lets the owner register a glitch-free ready.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CW'(1);
        end
    end

    assign full_next_c = (count_next == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/tm_master_reply_reorder.sv
// Buffers replies per return VC and releases them to the master in request order.
// Optional error checking and pending counters: define TM_REORDER_ERRCHK_EN.
module tm_master_reply_reorder
    import tm_reorder_pkg::*;
#(
    parameter int unsigned NUM_CREDITS      = 8,
    parameter int unsigned VC_ADDRESS_WIDTH = 2,
    parameter int unsigned WIDTH_DATA       = 36,
    parameter int unsigned ORDER_DEPTH      = 4 * NUM_CREDITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid_in,
    input  logic [VC_ADDRESS_WIDTH-1:0]   req_ret_vc_in,
    input  logic [NUM_VCS-1:0]            noc_valid_in,
    input  logic [NUM_VCS*WIDTH_DATA-1:0] noc_data_in,
    output logic [NUM_VCS-1:0]            noc_ready_out,
    output logic                          recv_valid_out,
    output logic [WIDTH_DATA-1:0]         recv_data_out,
    input  logic                          recv_ready_in,
    output logic [NUM_VCS-1:0]            receive_valid_out,
    output logic [ERR_W-1:0]              err_out
);

    logic                        ord_full_c;
    logic                        ord_empty_c;
    logic                        ord_push_c;
    logic                        unused_ord_full_next_c;
    logic [VC_ADDRESS_WIDTH-1:0] head_c;
    logic [NUM_VCS-1:0]          rep_push_c;
    logic [NUM_VCS-1:0]          rep_pop_c;
    logic [NUM_VCS-1:0]          rep_full_c;
    logic [NUM_VCS-1:0]          rep_empty_c;
    logic [NUM_VCS-1:0]          rep_full_next_c;
    logic [WIDTH_DATA-1:0]       rep_rdata_c [NUM_VCS];
    logic                        release_c;

    assign ord_push_c = req_valid_in & ~ord_full_c;

    tm_sync_fifo #(
        .WIDTH (VC_ADDRESS_WIDTH),
        .DEPTH (ORDER_DEPTH)
    ) u_order (
        .clk         (clk),
        .rst_n       (rst),
        .push        (ord_push_c),
        .wdata       (req_ret_vc_in),
        .pop         (release_c),
        .rdata_c     (head_c),
        .full_c      (ord_full_c),
        .empty_c     (ord_empty_c),
        .full_next_c (unused_ord_full_next_c)
    );

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_reply
        assign rep_push_c[v] = noc_valid_in[v] & noc_ready_out[v];
        assign rep_pop_c[v]  = release_c & (head_c == VC_ADDRESS_WIDTH'(v));

        tm_sync_fifo #(
            .WIDTH (WIDTH_DATA),
            .DEPTH (NUM_CREDITS)
        ) u_reply (
            .clk         (clk),
            .rst_n       (rst),
            .push        (rep_push_c[v]),
            .wdata       (noc_data_in[v*WIDTH_DATA +: WIDTH_DATA]),
            .pop         (rep_pop_c[v]),
            .rdata_c     (rep_rdata_c[v]),
            .full_c      (rep_full_c[v]),
            .empty_c     (rep_empty_c[v]),
            .full_next_c (rep_full_next_c[v])
        );
    end

    // Head-of-line release: the output register is free or drains this cycle.
    assign release_c = ~ord_empty_c & ~rep_empty_c[head_c]
                     & (~recv_valid_out | recv_ready_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            noc_ready_out     <= '0;
            recv_valid_out    <= 1'b0;
            recv_data_out     <= '0;
            receive_valid_out <= '0;
        end else begin
            noc_ready_out     <= ~rep_full_next_c;
            receive_valid_out <= '0;
            if (release_c) begin
                recv_valid_out    <= 1'b1;
                recv_data_out     <= rep_rdata_c[head_c];
                receive_valid_out <= NUM_VCS'(1) << head_c;
            end else if (recv_ready_in) begin
                recv_valid_out <= 1'b0;
            end
        end
    end

`ifdef TM_REORDER_ERRCHK_EN
    localparam int unsigned PEND_W = $clog2(NUM_CREDITS + 1) + 1;

    logic [NUM_VCS-1:0] unexp_c;
    logic [ERR_W-1:0]   err_q;

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_pend
        logic [PEND_W-1:0] pending;
        logic              inc_c;

        assign inc_c      = ord_push_c & (req_ret_vc_in == VC_ADDRESS_WIDTH'(v));
        assign unexp_c[v] = rep_push_c[v] & (pending == '0);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pending <= '0;
            end else if (inc_c && !rep_push_c[v]) begin
                pending <= pending + PEND_W'(1);
            end else if (!inc_c && rep_push_c[v] && (pending != '0)) begin
                pending <= pending - PEND_W'(1);
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            if (req_valid_in && ord_full_c) begin
                err_q[ERR_ORDER_OVF] <= 1'b1;
            end
            if (|unexp_c) begin
                err_q[ERR_UNEXP] <= 1'b1;
            end
            if (|(noc_valid_in & rep_full_c)) begin
                err_q[ERR_REPLY_OVF] <= 1'b1;
            end
        end
    end

    assign err_out = err_q;
`else
    logic unused_rep_full;

    assign unused_rep_full = |rep_full_c;
    assign err_out         = '0;
`endif

endmodule

// File: tb/tb_tm_master_reply_reorder.sv
// Directed self-checking bench for tm_master_reply_reorder.
// Honours TM_REORDER_ERRCHK_EN for the error-flag expectations.
module tb_tm_master_reply_reorder;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid_in;
    logic [1:0]   req_ret_vc_in;
    logic [3:0]   noc_valid_in;
    logic [143:0] noc_data_in;
    logic [3:0]   noc_ready_out;
    logic         recv_valid_out;
    logic [35:0]  recv_data_out;
    logic         recv_ready_in;
    logic [3:0]   receive_valid_out;
    logic [2:0]   err_out;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

`ifdef TM_REORDER_ERRCHK_EN
    localparam logic [2:0] EXP_ERR = 3'b010;
`else
    localparam logic [2:0] EXP_ERR = 3'b000;
`endif

    tm_master_reply_reorder dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_in      (req_valid_in),
        .req_ret_vc_in     (req_ret_vc_in),
        .noc_valid_in      (noc_valid_in),
        .noc_data_in       (noc_data_in),
        .noc_ready_out     (noc_ready_out),
        .recv_valid_out    (recv_valid_out),
        .recv_data_out     (recv_data_out),
        .recv_ready_in     (recv_ready_in),
        .receive_valid_out (receive_valid_out),
        .err_out           (err_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (receive_valid_out != 4'b0) pulse_cnt = pulse_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_reply(input int v, input logic [35:0] d);
        noc_valid_in = 4'(1 << v);
        noc_data_in  = '0;
        noc_data_in[v*36 +: 36] = d;
    endtask

    task automatic clear_reply();
        noc_valid_in = '0;
        noc_data_in  = '0;
    endtask

    task automatic push_req(input int v);
        req_valid_in  = 1'b1;
        req_ret_vc_in = 2'(v);
        step();
        req_valid_in  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid_in = 1'b0; req_ret_vc_in = '0; recv_ready_in = 1'b0;
        clear_reply();
        #2 rst = 1'b0;
        step(); step();
        checks++; if (recv_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", recv_valid_out); end
        checks++; if (recv_data_out !== 36'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", recv_data_out); end
        checks++; if (receive_valid_out !== 4'h0) begin errors++; $display("FAIL reset_pulse: got %h expected 0", receive_valid_out); end
        checks++; if (noc_ready_out !== 4'h0) begin errors++; $display("FAIL reset_ready: got %h expected 0", noc_ready_out); end
        checks++; if (err_out !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", err_out); end
        rst = 1'b1;
        step();
        checks++; if (noc_ready_out !== 4'hF) begin errors++; $display("FAIL reset_ready_after: got %h expected f", noc_ready_out); end
    endtask

    task automatic test_in_order();
        logic [35:0] exp_d;
        logic [3:0]  exp_p;
        recv_ready_in = 1'b1;
        for (int v = 0; v < 3; v++) push_req(v);
        for (int v = 2; v >= 0; v--) begin
            put_reply(v, 36'hA0000_0000 | 36'(v));
            step();
        end
        clear_reply();
        checks++; if (recv_valid_out !== 1'b0) begin errors++; $display("FAIL inorder_latency: got %b expected 0", recv_valid_out); end
        for (int k = 0; k < 3; k++) begin
            step();
            exp_d = 36'hA0000_0000 | 36'(k);
            exp_p = 4'(1 << k);
            checks++; if (recv_valid_out !== 1'b1) begin errors++; $display("FAIL inorder_valid%0d: got %b expected 1", k, recv_valid_out); end
            checks++; if (recv_data_out !== exp_d) begin errors++; $display("FAIL inorder_data%0d: got %h expected %h", k, recv_data_out, exp_d); end
            checks++; if (receive_valid_out !== exp_p) begin errors++; $display("FAIL inorder_pulse%0d: got %h expected %h", k, receive_valid_out, exp_p); end
        end
        step();
        checks++; if (recv_valid_out !== 1'b0 || receive_valid_out !== 4'h0) begin errors++; $display("FAIL inorder_idle: got %b/%h expected 0/0", recv_valid_out, receive_valid_out); end
    endtask

    task automatic test_backpressure();
        recv_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) push_req(0);
        put_reply(0, 36'hB0000_0000);
        step();
        checks++; if (recv_valid_out !== 1'b0) begin errors++; $display("FAIL bp_pre: got %b expected 0", recv_valid_out); end
        put_reply(0, 36'hB0000_0001);
        step();
        checks++; if (recv_valid_out !== 1'b1 || recv_data_out !== 36'hB0000_0000 || receive_valid_out !== 4'h1) begin
            errors++; $display("FAIL bp_first: got %b/%h/%h expected 1/b00000000/1", recv_valid_out, recv_data_out, receive_valid_out); end
        put_reply(0, 36'hB0000_0002);
        step();
        clear_reply();
        for (int i = 0; i < 4; i++) begin
            checks++; if (recv_valid_out !== 1'b1 || recv_data_out !== 36'hB0000_0000 || receive_valid_out !== 4'h0) begin
                errors++; $display("FAIL bp_hold%0d: got %b/%h/%h expected 1/b00000000/0", i, recv_valid_out, recv_data_out, receive_valid_out); end
            if (i < 3) step();
        end
        recv_ready_in = 1'b1;
        step();
        checks++; if (recv_valid_out !== 1'b1 || recv_data_out !== 36'hB0000_0001 || receive_valid_out !== 4'h1) begin
            errors++; $display("FAIL bp_beat1: got %b/%h/%h expected 1/b00000001/1", recv_valid_out, recv_data_out, receive_valid_out); end
        step();
        checks++; if (recv_valid_out !== 1'b1 || recv_data_out !== 36'hB0000_0002 || receive_valid_out !== 4'h1) begin
            errors++; $display("FAIL bp_beat2: got %b/%h/%h expected 1/b00000002/1", recv_valid_out, recv_data_out, receive_valid_out); end
        step();
        checks++; if (recv_valid_out !== 1'b0 || receive_valid_out !== 4'h0) begin errors++; $display("FAIL bp_idle: got %b/%h expected 0/0", recv_valid_out, receive_valid_out); end
    endtask

    task automatic test_full();
        int n = 0;
        int budget = 0;
        logic [35:0] exp_d;
        logic [3:0]  exp_p;
        recv_ready_in = 1'b0;
        push_req(0);
        for (int i = 0; i < 8; i++) push_req(3);
        for (int i = 0; i < 8; i++) begin
            put_reply(3, 36'hF0000_0000 | 36'(i));
            step();
            if (i == 6) begin
                checks++; if (noc_ready_out !== 4'hF) begin errors++; $display("FAIL full_ready7: got %h expected f", noc_ready_out); end
            end
        end
        clear_reply();
        checks++; if (noc_ready_out !== 4'h7) begin errors++; $display("FAIL full_ready8: got %h expected 7", noc_ready_out); end
        recv_ready_in = 1'b1;
        put_reply(0, 36'hD0000_0000);
        step();
        clear_reply();
        while (n < 9 && budget < 30) begin
            step();
            budget++;
            if (recv_valid_out) begin
                exp_d = (n == 0) ? 36'hD0000_0000 : (36'hF0000_0000 | 36'(n - 1));
                exp_p = (n == 0) ? 4'h1 : 4'h8;
                checks++; if (recv_data_out !== exp_d) begin errors++; $display("FAIL full_drain_data%0d: got %h expected %h", n, recv_data_out, exp_d); end
                checks++; if (receive_valid_out !== exp_p) begin errors++; $display("FAIL full_drain_pulse%0d: got %h expected %h", n, receive_valid_out, exp_p); end
                n++;
            end
        end
        checks++; if (n != 9) begin errors++; $display("FAIL full_drain_count: got %0d expected 9", n); end
        step();
        checks++; if (recv_valid_out !== 1'b0 || noc_ready_out !== 4'hF) begin errors++; $display("FAIL full_end: got %b/%h expected 0/f", recv_valid_out, noc_ready_out); end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [35:0] exp_d;
        logic [3:0]  exp_p;
        recv_ready_in = 1'b0;
        base = pulse_cnt;
        for (int i = 0; i < 32; i++) push_req(i % 4);
        for (int j = 0; j < 8; j++) begin
            noc_valid_in = 4'hF;
            for (int v = 0; v < 4; v++) noc_data_in[v*36 +: 36] = {4'(v), 32'(j)};
            step();
        end
        clear_reply();
        step(); step();
        checks++; if (noc_ready_out !== 4'h1) begin errors++; $display("FAIL b2b_ready: got %h expected 1", noc_ready_out); end
        recv_ready_in = 1'b1;
        for (int k = 0; k < 32; k++) begin
            exp_d = {4'(k % 4), 32'(k / 4)};
            exp_p = 4'(1 << (k % 4));
            checks++; if (recv_valid_out !== 1'b1 || recv_data_out !== exp_d) begin
                errors++; $display("FAIL b2b_beat%0d: got %b/%h expected 1/%h", k, recv_valid_out, recv_data_out, exp_d); end
            if (k > 0) begin
                checks++; if (receive_valid_out !== exp_p) begin errors++; $display("FAIL b2b_pulse%0d: got %h expected %h", k, receive_valid_out, exp_p); end
            end
            step();
        end
        checks++; if (recv_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", recv_valid_out); end
        checks++; if (pulse_cnt - base != 32) begin errors++; $display("FAIL b2b_pulses: got %0d expected 32", pulse_cnt - base); end
    endtask

    task automatic test_reset_mid();
        recv_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) push_req(1);
        for (int i = 0; i < 5; i++) begin
            put_reply(1, 36'hC0000_0000 | 36'(i));
            step();
        end
        clear_reply();
        step();
        checks++; if (recv_valid_out !== 1'b1) begin errors++; $display("FAIL rm_pre: got %b expected 1", recv_valid_out); end
        rst = 1'b0;
        #1;
        checks++; if (recv_valid_out !== 1'b0 || recv_data_out !== 36'h0 || receive_valid_out !== 4'h0 || noc_ready_out !== 4'h0 || err_out !== 3'b000) begin
            errors++; $display("FAIL rm_async: got %b/%h/%h/%h/%b expected all 0", recv_valid_out, recv_data_out, receive_valid_out, noc_ready_out, err_out); end
        step();
        rst = 1'b1;
        step();
        checks++; if (noc_ready_out !== 4'hF || recv_valid_out !== 1'b0) begin errors++; $display("FAIL rm_release: got %h/%b expected f/0", noc_ready_out, recv_valid_out); end
        step();
        checks++; if (recv_valid_out !== 1'b0) begin errors++; $display("FAIL rm_empty: got %b expected 0", recv_valid_out); end
        recv_ready_in = 1'b1;
        push_req(2);
        put_reply(2, 36'hE0000_0002);
        step();
        clear_reply();
        step();
        checks++; if (recv_valid_out !== 1'b1 || recv_data_out !== 36'hE0000_0002 || receive_valid_out !== 4'h4) begin
            errors++; $display("FAIL rm_fresh: got %b/%h/%h expected 1/e00000002/4", recv_valid_out, recv_data_out, receive_valid_out); end
        step();
        checks++; if (recv_valid_out !== 1'b0) begin errors++; $display("FAIL rm_end: got %b expected 0", recv_valid_out); end
    endtask

    task automatic test_err();
        recv_ready_in = 1'b1;
        put_reply(2, 36'h99999_9999);
        step();
        clear_reply();
        checks++; if (err_out !== EXP_ERR) begin errors++; $display("FAIL err_set: got %b expected %b", err_out, EXP_ERR); end
        checks++; if (recv_valid_out !== 1'b0) begin errors++; $display("FAIL err_noleak: got %b expected 0", recv_valid_out); end
        step(); step(); step();
        checks++; if (err_out !== EXP_ERR) begin errors++; $display("FAIL err_held: got %b expected %b", err_out, EXP_ERR); end
        rst = 1'b0;
        #1;
        checks++; if (err_out !== 3'b000) begin errors++; $display("FAIL err_clear: got %b expected 000", err_out); end
        step();
        rst = 1'b1;
        step();
        checks++; if (noc_ready_out !== 4'hF || err_out !== 3'b000) begin errors++; $display("FAIL err_after: got %h/%b expected f/000", noc_ready_out, err_out); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_backpressure();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
